// File: rtl/sync_fifo_32x8.sv
// 32x8 single-clock FIFO with occupancy count and active-low full/empty flags.
// Define FIFO_DEBUG_PORTS_EN to expose the FSM state and both pointers.
module sync_fifo_32x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  CLEAR_N,
    input  logic                  WRITE,
    input  logic                  READ,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  F_FULL_N,
    output logic                  F_EMPTY_N,
    output logic [ADDR_WIDTH-1:0] USE_DW
`ifdef FIFO_DEBUG_PORTS_EN
    ,
    output logic [1:0]            state,
    output logic [ADDR_WIDTH-1:0] countw,
    output logic [ADDR_WIDTH-1:0] countr
`endif
);

    // state     | meaning
    // ST_EMPTY  | no words stored (encoding 11 also behaves as empty)
    // ST_NORMAL | 1..30 words stored
    // ST_FULL   | 31 words stored; one RAM slot always left free
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_NORMAL = 2'b01,
        ST_FULL   = 2'b10
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LVL_ONE       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LVL_NEAR_FULL = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   countw_q, countw_d;
    logic [ADDR_WIDTH-1:0]   countr_q, countr_d;
    logic [ADDR_WIDTH-1:0]   used_q, used_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [DATA_WIDTH-1:0]   mem_q [0:(2**ADDR_WIDTH)-1];

    logic is_full, is_empty, wr_acc, rd_acc, wr_en;

    assign is_full  = (state_q == ST_FULL);
    assign is_empty = !((state_q == ST_NORMAL) || is_full);
    // A write into a full FIFO is fine when a read frees a slot on the same edge.
    assign wr_acc   = WRITE && (!is_full || READ);
    assign rd_acc   = READ && !is_empty;

    always_comb begin
        state_d  = state_q;
        countw_d = countw_q;
        countr_d = countr_q;
        used_d   = used_q;
        dout_d   = dout_q;
        wr_en    = 1'b0;
        if (!CLEAR_N) begin
            state_d  = ST_EMPTY;
            countw_d = '0;
            countr_d = '0;
            used_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_en    = 1'b1;
                countw_d = countw_q + 1'b1;
            end
            if (rd_acc) begin
                dout_d   = mem_q[countr_q];
                countr_d = countr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                used_d = used_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                used_d = used_q - 1'b1;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (wr_acc) state_d = ST_NORMAL;
                end
                ST_NORMAL: begin
                    if (wr_acc && !rd_acc && (used_q == LVL_NEAR_FULL)) begin
                        state_d = ST_FULL;
                    end else if (rd_acc && !wr_acc && (used_q == LVL_ONE)) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (rd_acc && !wr_acc) state_d = ST_NORMAL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q  <= ST_EMPTY;
            countw_q <= '0;
            countr_q <= '0;
            used_q   <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            countw_q <= countw_d;
            countr_q <= countr_d;
            used_q   <= used_d;
            dout_q   <= dout_d;
        end
    end

    // RAM is not reset; a same-edge read of the written slot sees the old word.
    always_ff @(posedge CLOCK) begin
        if (RESET_N && wr_en) begin
            mem_q[countw_q] <= DATA_IN;
        end
    end

    assign DATA_OUT  = dout_q;
    assign USE_DW    = used_q;
    assign F_FULL_N  = !is_full;
    assign F_EMPTY_N = !is_empty;

`ifdef FIFO_DEBUG_PORTS_EN
    assign state  = state_q;
    assign countw = countw_q;
    assign countr = countr_q;
`endif

endmodule

// File: tb/tb_sync_fifo_32x8.sv
// Self-checking bench for sync_fifo_32x8: directed scenarios plus random traffic,
// compared against a queue-based model of the FIFO.
module tb_sync_fifo_32x8;

    logic       clk;
    logic       rst_n, clr_n, wr, rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full_n, empty_n;
    logic [4:0] use_dw;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] model_q[$];
    logic [7:0] model_dout;

    sync_fifo_32x8 dut (
        .CLOCK    (clk),
        .RESET_N  (rst_n),
        .CLEAR_N  (clr_n),
        .WRITE    (wr),
        .READ     (rd),
        .DATA_IN  (din),
        .DATA_OUT (dout),
        .F_FULL_N (full_n),
        .F_EMPTY_N(empty_n),
        .USE_DW   (use_dw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge with the currently driven inputs, update the model, check outputs.
    task automatic tick();
        logic wacc, racc;
        int   sz;
        @(posedge clk);
        sz = model_q.size();
        if (!rst_n) begin
            model_q.delete();
            model_dout = 8'h00;
        end else if (!clr_n) begin
            model_q.delete();
        end else begin
            wacc = wr && ((sz != 31) || rd);
            racc = rd && (sz != 0);
            if (racc) model_dout = model_q.pop_front();
            if (wacc) model_q.push_back(din);
        end
        #1;
        check_eq("use_dw",  32'(use_dw),  32'(model_q.size()));
        check_eq("empty_n", 32'(empty_n), 32'(model_q.size() != 0));
        check_eq("full_n",  32'(full_n),  32'(model_q.size() != 31));
        check_eq("dout",    32'(dout),    32'(model_dout));
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        tick();
    endtask

    initial begin
        model_dout = 8'h00;
        rst_n = 1'b0; clr_n = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_use", 32'(use_dw), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'h00);

        // Reads on an empty FIFO are ignored.
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        check_eq("empty_rd_dout", 32'(dout), 32'h00);

        // Single write then read.
        drive(1'b1, 1'b0, 8'h25);
        check_eq("one_use", 32'(use_dw), 32'd1);
        drive(1'b0, 1'b1, 8'h00);
        check_eq("one_rd_dout", 32'(dout), 32'h25);

        // Fill to capacity, then one extra write.
        for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 8'h0B);
        check_eq("fill_use", 32'(use_dw), 32'd31);
        check_eq("fill_full_n", 32'(full_n), 32'd0);
        drive(1'b1, 1'b0, 8'hEE);
        check_eq("overfill_use", 32'(use_dw), 32'd31);

        // Drain completely, then one extra read.
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            check_eq("drain_dout", 32'(dout), 32'h0B);
        end
        check_eq("drain_use", 32'(use_dw), 32'd0);
        drive(1'b0, 1'b1, 8'h00);
        check_eq("underflow_dout", 32'(dout), 32'h0B);

        // Simultaneous read/write at level 5 across the pointer wrap.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 8'(8'h80 + i));
        check_eq("rw_use", 32'(use_dw), 32'd5);

        // Read+write while full keeps it full.
        for (int i = 0; i < 26; i++) drive(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'($urandom));
        check_eq("full_rw_use", 32'(use_dw), 32'd31);

        // Flush from level 10, then reuse.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'($urandom));
        clr_n = 1'b0;
        drive(1'b1, 1'b1, 8'hCC);
        clr_n = 1'b1;
        check_eq("clr_use", 32'(use_dw), 32'd0);
        check_eq("clr_empty_n", 32'(empty_n), 32'd0);
        drive(1'b1, 1'b0, 8'h5A);
        drive(1'b0, 1'b1, 8'h00);
        check_eq("clr_reuse_dout", 32'(dout), 32'h5A);

        // Random traffic with occasional flush/reset.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias  = (i / 300) % 3;
            clr_n = ($urandom_range(0, 199) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            case (bias)
                0:       begin wr = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0); end
                1:       begin wr = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0); end
                default: begin wr = $urandom_range(0, 1) != 0;   rd = $urandom_range(0, 1) != 0;   end
            endcase
            din = 8'($urandom);
            tick();
        end
        rst_n = 1'b1; clr_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
